// File: rtl/ones_pattern_gen.sv
// k-of-WIDTH combination enumerator: streams every WIDTH-bit word with exactly k
// set bits in increasing numeric order over a valid/ready interface.
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int IW    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CW-1:0]    i_count,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [IW-1:0]    o_index,
  output logic             o_busy,
  output logic             o_err,
  output logic             o_state
);

  // Handshake: a word moves when o_valid && i_ready at a rising edge; once raised,
  // o_valid stays high and o_data/o_index/o_last hold until that transfer happens.

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  localparam int XW = WIDTH + 1;
  localparam int SW = $clog2(XW);
  localparam logic [CW:0]   WIDTH_C  = (CW+1)'(WIDTH);
  localparam logic [XW-1:0] ALL_ONES = '1;

  state_t           state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] data_d;
  logic [IW-1:0]    index_d;
  logic             valid_d, err_d;

  logic [WIDTH-1:0] top_pattern;
  logic [XW-1:0]    x, c, r, succ_wide;
  logic [SW-1:0]    ctz;
  logic             too_many;

  function automatic logic [WIDTH-1:0] low_ones(input logic [CW-1:0] n);
    logic [XW-1:0] m;
    m = ~(ALL_ONES << n);
    return WIDTH'(m);
  endfunction

  // Final word of an enumeration has its k ones packed against the MSB.
  assign top_pattern = low_ones(k_q) << (WIDTH_C - {1'b0, k_q});
  assign o_last      = o_valid && (o_data == top_pattern);
  assign o_busy      = (state_q == S_EMIT);
  assign o_state     = state_q;
  assign too_many    = ({1'b0, i_count} > WIDTH_C);

  // Gosper successor, one bit wider so the carry out of r survives.
  always_comb begin
    x   = {1'b0, o_data};
    c   = x & (~x + XW'(1));
    r   = x + c;
    ctz = '0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (c[i]) ctz = SW'(i);
    end
    succ_wide = r | (((r ^ x) >> 2) >> ctz);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = o_data;
    index_d = o_index;
    valid_d = o_valid;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (too_many) begin
            err_d = 1'b1;
          end else begin
            k_d     = i_count;
            data_d  = low_ones(i_count);
            index_d = '0;
            valid_d = 1'b1;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (o_valid && i_ready) begin
          if (o_last) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            index_d = '0;
            data_d  = '0;
          end else begin
            data_d  = WIDTH'(succ_wide);
            index_d = o_index + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      o_data  <= '0;
      o_index <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      o_data  <= data_d;
      o_index <= index_d;
      o_valid <= valid_d;
      o_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: enumerations compared against a brute-force
// popcount reference, with backpressure, error, ignored-start and reset cases.
module tb_ones_pattern_gen;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
  localparam int IW    = 8;

  logic             i_clk, i_rst_n, i_start, i_ready;
  logic [CW-1:0]    i_count;
  logic             o_valid, o_last, o_busy, o_err, o_state;
  logic [WIDTH-1:0] o_data;
  logic [IW-1:0]    o_index;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] obs_data[$];
  logic [IW-1:0]    obs_idx[$];
  logic             obs_last[$];
  int               coll_cycles, stall_bad;
  bit               valid_drop, timed_out;

  ones_pattern_gen #(.WIDTH(WIDTH), .CW(CW), .IW(IW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_count(i_count),
    .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .o_index(o_index), .o_busy(o_busy), .o_err(o_err), .o_state(o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: every k-bit-popcount word, ascending.
  task automatic build_exp(input int k);
    exp_q.delete();
    for (int v = 0; v < (1 << WIDTH); v++) begin
      if ($countones(v) == k) exp_q.push_back(WIDTH'(v));
    end
  endtask

  // driver tasks (called at posedge+1)
  task automatic start_enum(input int k);
    i_start = 1'b1;
    i_count = CW'(k);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic collect(input bit bp, input int max_words, input int poke_at);
    logic [WIDTH-1:0] held;
    bit xfer, was_last;
    obs_data.delete(); obs_idx.delete(); obs_last.delete();
    coll_cycles = 0; stall_bad = 0; valid_drop = 0; timed_out = 0;
    while (1) begin
      if (!o_valid) begin valid_drop = 1; break; end
      i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (coll_cycles == poke_at) begin
        i_start = 1'b1; i_count = CW'(5);
      end else begin
        i_start = 1'b0;
      end
      xfer = i_ready; held = o_data; was_last = o_last;
      if (xfer) begin
        obs_data.push_back(o_data); obs_idx.push_back(o_index); obs_last.push_back(o_last);
      end
      @(posedge i_clk); #1;
      coll_cycles++;
      if (!xfer && o_data !== held) stall_bad++;
      if (xfer && was_last) break;
      if (obs_data.size() == max_words) break;
      if (coll_cycles > 2000) begin timed_out = 1; break; end
    end
    i_ready = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    tests++;
    if ({o_valid, o_data, o_last, o_index, o_busy, o_err, o_state} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b idx=%0d busy=%b err=%b, want all 0",
               o_valid, o_data, o_last, o_index, o_busy, o_err);
    end
  endtask

  task automatic test_sweep(input int k, input bit bp, input string name);
    int n;
    build_exp(k);
    n = exp_q.size();
    start_enum(k);
    tests++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_index !== '0 || o_data !== exp_q[0]) begin
      fails++;
      $display("FAIL %s_first: valid=%b busy=%b idx=%0d data=%h, want 1 1 0 %h",
               name, o_valid, o_busy, o_index, o_data, exp_q[0]);
    end
    collect(bp, 1000, -1);
    tests++;
    if (obs_data.size() != n || valid_drop || timed_out || stall_bad != 0) begin
      fails++;
      $display("FAIL %s_count: got %0d words drop=%b timeout=%b stall_changes=%0d, want %0d words clean",
               name, obs_data.size(), valid_drop, timed_out, stall_bad, n);
    end
    if (!bp) begin
      tests++;
      if (coll_cycles != n) begin
        fails++;
        $display("FAIL %s_throughput: %0d cycles for %0d words", name, coll_cycles, n);
      end
    end
    for (int i = 0; i < n && i < obs_data.size(); i++) begin
      tests++;
      if (obs_data[i] !== exp_q[i] || int'(obs_idx[i]) != i || obs_last[i] !== (i == n - 1)) begin
        fails++;
        $display("FAIL %s_word%0d: got data=%h idx=%0d last=%b, want %h %0d %b",
                 name, i, obs_data[i], obs_idx[i], obs_last[i], exp_q[i], i, (i == n - 1));
      end
      tests++;
      if ($countones(obs_data[i]) != k || (i > 0 && obs_data[i] <= obs_data[i-1])) begin
        fails++;
        $display("FAIL %s_order%0d: data=%h popcount=%0d, want popcount %0d and ascending",
                 name, i, obs_data[i], $countones(obs_data[i]), k);
      end
    end
    tests++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_index !== '0 || o_last !== 1'b0) begin
      fails++;
      $display("FAIL %s_end: valid=%b busy=%b idx=%0d last=%b, want 0 0 0 0",
               name, o_valid, o_busy, o_index, o_last);
    end
  endtask

  // k=0 then k=WIDTH back to back: each a single word, restart on the very next edge.
  task automatic test_back_to_back;
    int ks[2];
    logic [WIDTH-1:0] want[2];
    ks[0] = 0; ks[1] = WIDTH; want[0] = 8'h00; want[1] = 8'hFF;
    for (int j = 0; j < 2; j++) begin
      start_enum(ks[j]);
      tests++;
      if (o_valid !== 1'b1 || o_data !== want[j] || o_last !== 1'b1) begin
        fails++;
        $display("FAIL single_k%0d: valid=%b data=%h last=%b, want 1 %h 1",
                 ks[j], o_valid, o_data, o_last, want[j]);
      end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      tests++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        fails++;
        $display("FAIL single_k%0d_idle: valid=%b busy=%b, want 0 0", ks[j], o_valid, o_busy);
      end
    end
  endtask

  task automatic test_err;
    int bad[2];
    bad[0] = 9; bad[1] = 15;
    for (int j = 0; j < 2; j++) begin
      start_enum(bad[j]);
      tests++;
      if (o_err !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
        fails++;
        $display("FAIL err_k%0d: err=%b valid=%b busy=%b, want 1 0 0", bad[j], o_err, o_valid, o_busy);
      end
      @(posedge i_clk); #1;
      tests++;
      if (o_err !== 1'b0 || o_valid !== 1'b0) begin
        fails++;
        $display("FAIL err_k%0d_pulse: err=%b valid=%b one cycle later, want 0 0", bad[j], o_err, o_valid);
      end
    end
  endtask

  task automatic test_start_ignored;
    build_exp(3);
    start_enum(3);
    collect(1'b1, 1000, 5);
    tests++;
    if (obs_data.size() != exp_q.size() || valid_drop || timed_out) begin
      fails++;
      $display("FAIL restart_ignored_count: got %0d words, want %0d", obs_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
      tests++;
      if (obs_data[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL restart_ignored_word%0d: got %h, want %h", i, obs_data[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    build_exp(3);
    start_enum(3);
    collect(1'b0, 10, -1);
    tests++;
    if (obs_data.size() != 10 || o_valid !== 1'b1 || o_data !== exp_q[10]) begin
      fails++;
      $display("FAIL abort_pre: words=%0d valid=%b data=%h, want 10 1 %h",
               obs_data.size(), o_valid, o_data, exp_q[10]);
    end
    #2 i_rst_n = 1'b0;
    #1;
    tests++;
    if ({o_valid, o_data, o_last, o_index, o_busy, o_err} !== '0) begin
      fails++;
      $display("FAIL abort_async: valid=%b data=%h last=%b idx=%0d busy=%b err=%b, want all 0",
               o_valid, o_data, o_last, o_index, o_busy, o_err);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    start_enum(3);
    tests++;
    if (o_valid !== 1'b1 || o_data !== 8'h07 || o_index !== '0) begin
      fails++;
      $display("FAIL abort_restart: valid=%b data=%h idx=%0d, want 1 07 0", o_valid, o_data, o_index);
    end
    collect(1'b0, 1000, -1);
    tests++;
    if (obs_data.size() != exp_q.size() || obs_data[obs_data.size()-1] !== exp_q[exp_q.size()-1]) begin
      fails++;
      $display("FAIL abort_rerun: got %0d words, want %0d ending %h",
               obs_data.size(), exp_q.size(), exp_q[exp_q.size()-1]);
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_count = '0; i_ready = 1'b0;
    #23 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    test_reset;
    test_sweep(1, 1'b0, "k1");
    test_sweep(2, 1'b0, "k2");
    test_sweep(4, 1'b1, "k4_bp");
    test_back_to_back;
    test_err;
    test_start_ignored;
    test_reset_abort;
    for (int j = 0; j < 4; j++) test_sweep(int'($urandom_range(0, WIDTH)), 1'b1, "rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
